regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and the long-latency result unit (multiply/divide, cache-miss loads). Long-latency results are captured in a one-entry holding buffer. The pipeline normally wins the port, and a starvation counter forces the buffer through after a bounded wait. The block drives the register file's `load`/`dest`/`in` inputs and exports the buffered destination to decode-stage hazard logic.

## Interface
- `STARVE_LIMIT`, default 4: maximum number of consecutive cycles the buffered result loses arbitration before it is forced through; legal range 1..15.
- `CNT_W`, default `$clog2(STARVE_LIMIT+1)`: starvation counter width; derived, not overridden.

- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `pipe_valid`  in  1  pipeline WB stage holds a result.
- `pipe_ready`  out  1  pipeline result is consumed this cycle; 0 stalls the WB stage.
- `pipe_dest`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline result.
- `lu_valid`  in  1  long-latency unit offers a result.
- `lu_ready`  out  1  holding buffer can accept.
- `lu_dest`  in  5  long-latency destination register.
- `lu_data`  in  32  long-latency result.
- `wb_load`  out  1  register file write enable.
- `wb_dest`  out  5  register file write index.
- `wb_data`  out  32  register file write data.
- `pend_valid`  out  1  a buffered result awaits writeback.
- `pend_dest`  out  5  destination of the buffered result.
- `starve_grant`  out  1  buffer granted by starvation override this cycle (performance counter tap).

## Operation
- **State:** `buf_valid`, `buf_dest`, `buf_data`, `starve_cnt[CNT_W]`.
- **Buffer acceptance:**
  - `lu_ready = !buf_valid && !rst`.
  - On an `lu_valid && lu_ready` edge, the buffer loads `lu_dest`/`lu_data` and `buf_valid` becomes 1.
  - If `lu_dest == 0`, the handshake completes but `buf_valid` stays 0 (result discarded).
  - There is no same-cycle refill while draining.
- **Arbitration:**
  - `starve_hit = (starve_cnt == STARVE_LIMIT)`.
  - `grant_buf = buf_valid && (!pipe_valid || starve_hit)`.
  - `pipe_ready = !(buf_valid && starve_hit) && !rst`. This does not depend on `pipe_valid`.
- **Write port:**
  - When `grant_buf`: `wb_load = 1`, `wb_dest = buf_dest`, `wb_data = buf_data`. `buf_valid` clears at the next edge.
  - Otherwise: `wb_load = pipe_valid && pipe_ready && (pipe_dest != 0)`, `wb_dest = pipe_dest`, `wb_data = pipe_data`.
  - A pipeline result with `pipe_dest == 0` is consumed without a write.
- **Starvation counter:**
  - Cleared when `!buf_valid` or `grant_buf`.
  - Incremented when `buf_valid && !grant_buf`.
  - Saturates at `STARVE_LIMIT`.
- **Other outputs:**
  - `starve_grant = grant_buf && pipe_valid`.
  - `pend_valid = buf_valid`, `pend_dest = buf_dest`.
- **Ordering:** WAW ordering is enforced upstream by decode, using `pend_*` and in-flight tracking. It is illegal for `pipe_valid && buf_valid && pipe_dest == buf_dest != 0`; the bench asserts this never occurs.

## Timing
- **Reset:** while `rst` is high, `buf_valid = 0` and `starve_cnt = 0` at each edge. During `rst`, `lu_ready = 0`, `pipe_ready = 0`, and `wb_load = 0`. A buffered result present when `rst` rises is discarded.
- **Latency:** accept at edge N gives `pend_valid = 1` in cycle N+1. With the pipeline idle, `wb_load` comes from the buffer in cycle N+1, and the register file captures it at edge N+1.
- **Worst case under continuous pipeline traffic:** the buffer is written in cycle N+1+`STARVE_LIMIT`. The pipeline stalls exactly that one cycle.
- **Throughput:** the long-latency path accepts at most one result every 2 cycles.
- **Combinational paths:**
  - `pipe_*` and buffer state feed the `wb_*` outputs.
  - There is no combinational path from `lu_valid` to any output.
  - `pipe_valid` affects only `wb_*` and `starve_grant`.

## Structure
- Shared package `rv32i_types`:
  - `regidx_t` (`logic [4:0]`)
  - `rv32i_word` (`logic [31:0]`)
  - `wb_req_t` struct {`valid`, `dest`, `data`}, used for both requester bundles internally.
- No sub-module. The holding buffer and counter are small enough to stay inline; the arbitration is a single `always_comb`.

## Test plan
- **Idle buffer:** pipe writes x5 = 0x1234 each cycle, `lu_valid = 0` -> `wb_load = 1`, `wb_dest = 5`, `pipe_ready = 1` every cycle, `pend_valid = 0`.
- **Idle pipeline:** `lu_valid` with x7 = 0xDEADBEEF at edge N, `pipe_valid = 0` -> cycle N+1 shows `wb_dest = 7`, `wb_data = 0xDEADBEEF`, `lu_ready = 0`. Cycle N+2 shows `lu_ready = 1`, `pend_valid = 0`.
- **Starvation, `STARVE_LIMIT = 4`:** continuous pipe traffic, lu x9 accepted at edge N -> x9 written in cycle N+5 with `pipe_ready = 0` and `starve_grant = 1` for that cycle only. The pipe resumes in N+6.
- **x0 handling:** lu x0 = 0xFFFFFFFF and pipe x0 = 0x1 -> both handshakes complete, `wb_load` never asserts, `pend_valid` stays 0.
- **Back-to-back lu results:** two results offered continuously -> second accepted no earlier than 2 cycles after the first; `lu_ready` toggles 1,0,1.
- **Reset mid-operation:** buffer holds x3 with `starve_cnt = 2`, `rst` pulsed for 1 cycle -> during reset, `wb_load = 0`, `pipe_ready = 0`, `lu_ready = 0`. Afterwards `pend_valid = 0`, x3 is never written, and the counter restarts at 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: register index, machine word and the
// valid/dest/data bundle used by writeback requesters.
package rv32i_types;

   typedef logic [4:0]  regidx_t;
   typedef logic [31:0] rv32i_word;

   typedef struct packed {
      logic      valid;
      regidx_t   dest;
      rv32i_word data;
   } wb_req_t;

   localparam regidx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback normally wins, a one-entry
// holding buffer carries long-latency results and is forced through after STARVE_LIMIT losses.
module regfile_wb_arbiter
   import rv32i_types::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             pipe_valid,
   output logic             pipe_ready,
   input  regidx_t          pipe_dest,
   input  rv32i_word        pipe_data,
   input  logic             lu_valid,
   output logic             lu_ready,
   input  regidx_t          lu_dest,
   input  rv32i_word        lu_data,
   output logic             wb_load,
   output regidx_t          wb_dest,
   output rv32i_word        wb_data,
   output logic             pend_valid,
   output regidx_t          pend_dest,
   output logic             starve_grant
);

   logic             r_buf_valid;
   regidx_t          r_buf_dest;
   rv32i_word        r_buf_data;
   logic [CNT_W-1:0] r_starve_cnt;

   wb_req_t          w_pipe_req;
   wb_req_t          w_buf_req;
   logic             w_starve_hit;
   logic             w_grant_buf;
   logic             w_lu_accept;

   assign w_pipe_req   = '{valid: pipe_valid, dest: pipe_dest, data: pipe_data};
   assign w_buf_req    = '{valid: r_buf_valid, dest: r_buf_dest, data: r_buf_data};

   assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
   // Reset masks the grant so a stale buffer entry can never reach the register file.
   assign w_grant_buf  = w_buf_req.valid && (!w_pipe_req.valid || w_starve_hit) && !rst;

   assign lu_ready     = !r_buf_valid && !rst;
   assign pipe_ready   = !(r_buf_valid && w_starve_hit) && !rst;
   assign w_lu_accept  = lu_valid && lu_ready;

   assign starve_grant = w_grant_buf && w_pipe_req.valid;
   assign pend_valid   = r_buf_valid;
   assign pend_dest    = r_buf_dest;

   always_comb begin
      wb_load = 1'b0;
      wb_dest = w_pipe_req.dest;
      wb_data = w_pipe_req.data;
      if (w_grant_buf) begin
         wb_load = 1'b1;
         wb_dest = w_buf_req.dest;
         wb_data = w_buf_req.data;
      end else begin
         wb_load = w_pipe_req.valid && pipe_ready && (w_pipe_req.dest != REG_ZERO);
      end
   end

   // Control state: an x0 result completes its handshake but never occupies the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf_valid  <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         if (w_grant_buf) begin
            r_buf_valid <= 1'b0;
         end else if (w_lu_accept) begin
            r_buf_valid <= (lu_dest != REG_ZERO);
         end

         if (!r_buf_valid || w_grant_buf) begin
            r_starve_cnt <= '0;
         end else if (!w_starve_hit) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_lu_accept) begin
         r_buf_dest <= lu_dest;
         r_buf_data <= lu_data;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with STARVE_LIMIT = 4.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid;
   logic        pipe_ready;
   logic [4:0]  pipe_dest;
   logic [31:0] pipe_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_dest;
   logic [31:0] lu_data;
   logic        wb_load;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic        pend_valid;
   logic [4:0]  pend_dest;
   logic        starve_grant;

   int n_checks = 0;
   int n_err    = 0;
   logic saw_x3_write = 1'b0;
   logic saw_waw      = 1'b0;

   regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_valid   (pipe_valid),
      .pipe_ready   (pipe_ready),
      .pipe_dest    (pipe_dest),
      .pipe_data    (pipe_data),
      .lu_valid     (lu_valid),
      .lu_ready     (lu_ready),
      .lu_dest      (lu_dest),
      .lu_data      (lu_data),
      .wb_load      (wb_load),
      .wb_dest      (wb_dest),
      .wb_data      (wb_data),
      .pend_valid   (pend_valid),
      .pend_dest    (pend_dest),
      .starve_grant (starve_grant)
   );

   always #5 clk = ~clk;

   // Watch for writes of x3 after it was discarded, and for illegal WAW overlap.
   always @(negedge clk) begin
      if (!rst && wb_load && wb_dest == 5'd3) saw_x3_write = 1'b1;
      if (pipe_valid && pend_valid && pipe_dest == pend_dest && pipe_dest != 5'd0) saw_waw = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pipe_valid = 1'b1; pipe_dest = 5'd5; pipe_data = 32'h1234;
      lu_valid = 1'b1; lu_dest = 5'd3; lu_data = 32'h3333;
      tick();
      #1;
      chk("rst_wb_load", wb_load, 0);
      chk("rst_pipe_ready", pipe_ready, 0);
      chk("rst_lu_ready", lu_ready, 0);
      chk("rst_pend_valid", pend_valid, 0);
      tick();

      // Idle buffer: pipeline writes x5 every cycle
      rst = 1'b0; lu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pipe_data = 32'h1234;
         #1;
         chk("idle_buf_load", wb_load, 1);
         chk("idle_buf_dest", wb_dest, 5);
         chk("idle_buf_data", wb_data, 32'h1234);
         chk("idle_buf_pready", pipe_ready, 1);
         chk("idle_buf_pend", pend_valid, 0);
         tick();
      end

      // Idle pipeline: x7 = DEADBEEF
      pipe_valid = 1'b0; lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'hDEADBEEF;
      #1;
      chk("idle_pipe_lready0", lu_ready, 1);
      chk("idle_pipe_noload", wb_load, 0);
      tick();
      lu_valid = 1'b0;
      #1;
      chk("idle_pipe_pend", pend_valid, 1);
      chk("idle_pipe_pdest", pend_dest, 7);
      chk("idle_pipe_load", wb_load, 1);
      chk("idle_pipe_dest", wb_dest, 7);
      chk("idle_pipe_data", wb_data, 32'hDEADBEEF);
      chk("idle_pipe_lready1", lu_ready, 0);
      chk("idle_pipe_sgrant", starve_grant, 0);
      tick();
      #1;
      chk("idle_pipe_lready2", lu_ready, 1);
      chk("idle_pipe_pend2", pend_valid, 0);
      chk("idle_pipe_noload2", wb_load, 0);

      // Starvation: continuous pipe x10 traffic, lu x9 accepted at edge N
      pipe_valid = 1'b1; pipe_dest = 5'd10; pipe_data = 32'hA0;
      lu_valid = 1'b1; lu_dest = 5'd9; lu_data = 32'h99;
      #1;
      chk("starve_lready", lu_ready, 1);
      tick();
      lu_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         pipe_data = 32'hA0 + k;
         #1;
         chk("starve_wait_pready", pipe_ready, 1);
         chk("starve_wait_sgrant", starve_grant, 0);
         chk("starve_wait_dest", wb_dest, 10);
         chk("starve_wait_data", wb_data, 32'hA0 + k);
         chk("starve_wait_pend", pend_valid, 1);
         tick();
      end
      #1;
      chk("starve_hit_pready", pipe_ready, 0);
      chk("starve_hit_sgrant", starve_grant, 1);
      chk("starve_hit_load", wb_load, 1);
      chk("starve_hit_dest", wb_dest, 9);
      chk("starve_hit_data", wb_data, 32'h99);
      tick();
      #1;
      chk("starve_after_pready", pipe_ready, 1);
      chk("starve_after_sgrant", starve_grant, 0);
      chk("starve_after_dest", wb_dest, 10);
      chk("starve_after_pend", pend_valid, 0);

      // x0 handling on both requesters
      pipe_dest = 5'd0; pipe_data = 32'h1;
      lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'hFFFFFFFF;
      #1;
      chk("x0_noload", wb_load, 0);
      chk("x0_lready", lu_ready, 1);
      chk("x0_pready", pipe_ready, 1);
      tick();
      lu_valid = 1'b0;
      #1;
      chk("x0_pend", pend_valid, 0);
      chk("x0_noload2", wb_load, 0);
      chk("x0_lready2", lu_ready, 1);
      tick();

      // Back-to-back lu results: x12 then x13 offered continuously
      pipe_valid = 1'b0;
      lu_valid = 1'b1; lu_dest = 5'd12; lu_data = 32'h1111;
      #1;
      chk("b2b_lready_a", lu_ready, 1);
      tick();
      lu_dest = 5'd13; lu_data = 32'h2222;
      #1;
      chk("b2b_lready_b", lu_ready, 0);
      chk("b2b_first_dest", wb_dest, 12);
      chk("b2b_first_data", wb_data, 32'h1111);
      tick();
      #1;
      chk("b2b_lready_c", lu_ready, 1);
      chk("b2b_pend_gap", pend_valid, 0);
      tick();
      lu_valid = 1'b0;
      #1;
      chk("b2b_second_pdest", pend_dest, 13);
      chk("b2b_second_load", wb_load, 1);
      chk("b2b_second_data", wb_data, 32'h2222);
      tick();

      // Reset mid-operation: buffer holds x3 with counter at 2
      pipe_valid = 1'b1; pipe_dest = 5'd4; pipe_data = 32'h44;
      lu_valid = 1'b1; lu_dest = 5'd3; lu_data = 32'h33;
      tick();
      lu_valid = 1'b0;
      tick();
      tick();
      #1;
      chk("rstmid_pend_before", pend_dest, 3);
      rst = 1'b1;
      #1;
      chk("rstmid_noload", wb_load, 0);
      chk("rstmid_pready", pipe_ready, 0);
      chk("rstmid_lready", lu_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("rstmid_pend_after", pend_valid, 0);
      chk("rstmid_pipe_load", wb_load, 1);
      chk("rstmid_pipe_dest", wb_dest, 4);
      // Counter restarts from 0: a fresh x6 needs four full losing cycles
      lu_valid = 1'b1; lu_dest = 5'd6; lu_data = 32'h66;
      tick();
      lu_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("rstmid_wait_sgrant", starve_grant, 0);
         chk("rstmid_wait_pready", pipe_ready, 1);
         tick();
      end
      #1;
      chk("rstmid_hit_sgrant", starve_grant, 1);
      chk("rstmid_hit_dest", wb_dest, 6);
      tick();

      pipe_valid = 1'b0;
      tick();
      tick();
      chk("never_wrote_x3", saw_x3_write, 0);
      chk("no_waw_overlap", saw_waw, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
